ysyx_22040237_lsu: RTL
======================

Name: ysyx_22040237_lsu

Overview:
Load/store unit that consumes the execute stage's load/store command (ls info bus, computed address, store data) and drives a single-outstanding, request/grant/response data-memory port. It generates byte-lane masks and aligned store data, extracts and sign/zero-extends load data, and presents a registered writeback result. Non-memory instructions pass through with one cycle of latency. The unit stalls upstream via ready while a memory access is in flight.

Parameters:
XLEN, 64, data/address width
TIMEOUT_CYC, 255, response-wait cycles before an access is flagged as an error (optional feature only)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
valid_i  in  1  upstream instruction valid
ready_o  out  1  unit can accept an instruction this cycle
rd_wr_en_i  in  1  destination write enable
rd_idx_i  in  5  destination register index
alu_res_i  in  XLEN  ALU result; the effective address for load/store
ls_info_bus_i  in  7  {dw, word, half, byte, usign, store, load}, bit0 = load
rs2_store_i  in  XLEN  store data, right-aligned
mem_req_o  out  1  memory request
mem_we_o  out  1  1 = write
mem_addr_o  out  XLEN  8-byte-aligned address, alu_res_i with [2:0] forced to 0
mem_wdata_o  out  XLEN  lane-shifted store data
mem_wmask_o  out  8  byte-lane enables
mem_gnt_i  in  1  request accepted
mem_rvalid_i  in  1  response valid; rdata valid for loads, acknowledgement for stores
mem_rdata_i  in  XLEN  read data
wb_valid_o  out  1  writeback result valid, 1-cycle pulse
rd_wr_en_o  out  1  registered write enable
rd_idx_o  out  5  registered destination index
rd_wdata_o  out  XLEN  writeback data
ls_err_o  out  1  1-cycle pulse on misaligned access (or timeout)

Behaviour:
- Reset values: all outputs 0 except ready_o = 1; state = IDLE.
- FSM states: IDLE, REQ, WAIT.
- IDLE, ready_o = 1. On valid_i:
  - Neither load nor store: next cycle wb_valid_o = 1; rd_* registered from inputs; rd_wdata_o = alu_res_i.
  - Misaligned access (half with addr[0] != 0, word with addr[1:0] != 0, dw with addr[2:0] != 0): no memory request; next cycle ls_err_o = 1, wb_valid_o = 1, rd_wr_en_o = 0.
  - Otherwise: capture addr offset, size, usign, store, rd_*, and store data; go to REQ.
- REQ:
  - mem_req_o = 1 with stable addr/we/wdata/wmask; ready_o = 0.
  - mem_gnt_i advances to WAIT.
  - gnt and rvalid together in the same cycle complete the access as in WAIT.
- WAIT:
  - mem_req_o = 0; waits for mem_rvalid_i.
  - On rvalid: wb_valid_o pulses the next cycle and the state returns to IDLE.
  - ready_o rises in the same cycle as wb_valid_o.
  - Store writeback always has rd_wr_en_o = 0.
- Size and mask:
  - byte: mask = 8'b1 << off
  - half: mask = 8'b11 << off
  - word: mask = 8'hF << off
  - dw: mask = 8'hFF
  - off = addr[2:0]
- Store data: mem_wdata_o = rs2_store_i << (8*off).
- Load data:
  - shifted = mem_rdata_i >> (8*off), truncated to the access size.
  - Sign-extended when usign = 0, zero-extended when usign = 1.
  - dw ignores usign.
- Size encoding: exactly one size bit is expected. If none is set, the access is treated as dw. If several are set, the widest wins.
- Latency: minimum load/store = 3 cycles from accept to wb_valid_o (accept, REQ with gnt, rvalid in WAIT); 2 cycles if gnt and rvalid coincide.
- Reset while in REQ or WAIT aborts the access: outputs return to reset values and any late rvalid is ignored. The memory side must tolerate the dropped response.
- valid_i while ready_o = 0 is ignored; upstream holds its inputs.

Optional Feature:
YSYX_22040237_LSU_TIMEOUT_EN
- Defined:
  - An 8-bit counter runs in REQ/WAIT and resets on each state entry.
  - Reaching TIMEOUT_CYC returns the FSM to IDLE with ls_err_o = 1, wb_valid_o = 1, rd_wr_en_o = 0.
- Undefined: no counter; the FSM waits indefinitely and ls_err_o reports misalignment only.

Test Plan:
- lb, addr=0x8000_0003, rdata=0x0000_0000_8000_0000, gnt and rvalid the next cycle -> mem_addr_o=0x8000_0000, wmask irrelevant, rd_wdata_o=0xFFFF_FFFF_FFFF_FF80 (byte 3 = 0x80 sign-extended); lbu -> 0x80.
- sh, addr=0x8000_0006, rs2=0x1234 -> mem_wmask_o=8'hC0, mem_wdata_o=0x1234_0000_0000_0000, mem_we_o=1, wb_valid_o with rd_wr_en_o=0.
- lw, addr=0x8000_0002 -> no mem_req_o, ls_err_o pulse, wb_valid_o with rd_wr_en_o=0.
- ld, addr=0x8000_0008, gnt withheld 4 cycles, rvalid 2 cycles later with 0xDEAD_BEEF_CAFE_F00D -> ready_o=0 throughout, rd_wdata_o=0xDEAD_BEEF_CAFE_F00D, exactly one wb_valid_o pulse.
- ALU op (ls_info=0), alu_res=0x55, rd_idx=7 -> next cycle wb_valid_o=1, rd_idx_o=7, rd_wdata_o=0x55.
- rst low during WAIT, then rvalid -> ready_o=1, no wb_valid_o; with the timeout macro defined, no rvalid for 255 cycles -> ls_err_o pulse.

Source files
------------

// File: rtl/ysyx_22040237_lsu_if.sv
// ysyx_22040237_lsu_if
//   Data-memory port of the load/store unit: a single-outstanding
//   request/grant/response bus.
//
//   req    : master -> slave, request held until gnt
//   we     : master -> slave, 1 = write, 0 = read
//   addr   : master -> slave, 8-byte-aligned address
//   wdata  : master -> slave, lane-shifted store data
//   wmask  : master -> slave, byte-lane enables
//   gnt    : slave -> master, request accepted
//   rvalid : slave -> master, response valid (read data or write ack)
//   rdata  : slave -> master, read data
//
//   Modports: master (the LSU), slave (the memory).
interface ysyx_22040237_lsu_if #(
    parameter int XLEN = 64
);
    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [7:0]      wmask;
    logic            gnt;
    logic            rvalid;
    logic [XLEN-1:0] rdata;

    modport master (
        output req, we, addr, wdata, wmask,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, wmask,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/ysyx_22040237_lsu.sv
// ysyx_22040237_lsu
//   Load/store unit. Takes the execute stage's load/store command, drives a
//   single-outstanding data-memory port, aligns store data, extracts and
//   extends load data and presents a registered writeback result.
//   Non-memory instructions pass through with one cycle of latency.
//
//   Ports:
//     clk, rst          clock, synchronous active-low reset
//     valid_i/ready_o   upstream handshake; ready_o low while an access is in flight
//     rd_wr_en_i, rd_idx_i, alu_res_i, ls_info_bus_i, rs2_store_i
//                       instruction fields; alu_res_i is the effective address
//                       ls_info_bus_i = {dw, word, half, byte, usign, store, load}
//     mem               data-memory bus (ysyx_22040237_lsu_if.master)
//     wb_valid_o, rd_wr_en_o, rd_idx_o, rd_wdata_o
//                       registered writeback result, wb_valid_o is a 1-cycle pulse
//     ls_err_o          1-cycle pulse on misaligned access (or timeout)
//
//   Optional feature: define YSYX_22040237_LSU_TIMEOUT_EN to abort an access
//   with ls_err_o after TIMEOUT_CYC cycles in REQ or WAIT. Without it the unit
//   waits for the memory indefinitely.
module ysyx_22040237_lsu #(
    parameter int XLEN = 64
`ifdef YSYX_22040237_LSU_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 255
`endif
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic                  rd_wr_en_i,
    input  logic [4:0]            rd_idx_i,
    input  logic [XLEN-1:0]       alu_res_i,
    input  logic [6:0]            ls_info_bus_i,
    input  logic [XLEN-1:0]       rs2_store_i,

    ysyx_22040237_lsu_if.master   mem,

    output logic                  wb_valid_o,
    output logic                  rd_wr_en_o,
    output logic [4:0]            rd_idx_o,
    output logic [XLEN-1:0]       rd_wdata_o,
    output logic                  ls_err_o
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_t;

    state_t          state;

    // Access attributes captured at accept time
    logic [2:0]      off_q;
    size_t           size_q;
    logic            usign_q;
    logic            store_q;
    logic            rd_wr_en_q;
    logic [4:0]      rd_idx_q;

`ifdef YSYX_22040237_LSU_TIMEOUT_EN
    logic [7:0]      tmo_cnt;
`endif

    // Decode of the incoming command
    logic            is_load;
    logic            is_store;
    size_t           req_size;
    logic [2:0]      off;
    logic            misaligned;
    logic [7:0]      lane_mask;
    logic [XLEN-1:0] lane_wdata;

    // Size bits are expected one-hot; the widest set bit wins and an empty
    // size field is treated as a doubleword access.
    always_comb begin
        is_load  = ls_info_bus_i[0];
        is_store = ls_info_bus_i[1];
        off      = alu_res_i[2:0];

        if (ls_info_bus_i[6] || (ls_info_bus_i[5:3] == 3'b000)) begin
            req_size = SZ_D;
        end else if (ls_info_bus_i[5]) begin
            req_size = SZ_W;
        end else if (ls_info_bus_i[4]) begin
            req_size = SZ_H;
        end else begin
            req_size = SZ_B;
        end

        case (req_size)
            SZ_B: begin
                misaligned = 1'b0;
                lane_mask  = 8'b0000_0001 << off;
            end
            SZ_H: begin
                misaligned = off[0];
                lane_mask  = 8'b0000_0011 << off;
            end
            SZ_W: begin
                misaligned = (off[1:0] != 2'b00);
                lane_mask  = 8'b0000_1111 << off;
            end
            default: begin
                misaligned = (off != 3'b000);
                lane_mask  = 8'hFF;
            end
        endcase

        lane_wdata = rs2_store_i << {off, 3'b000};
    end

    // Load data: bring the addressed lane down to bit 0, then extend to XLEN
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] load_data;

    always_comb begin
        shifted = mem.rdata >> {off_q, 3'b000};
        case (size_q)
            SZ_B: load_data = usign_q ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                      : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            SZ_H: load_data = usign_q ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                      : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            SZ_W: load_data = usign_q ? {{(XLEN-32){1'b0}}, shifted[31:0]}
                                      : {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            default: load_data = shifted;
        endcase
    end

    // A grant arriving together with the response finishes the access
    // straight from REQ without visiting WAIT.
    logic rsp_done;
    assign rsp_done = ((state == REQ) && mem.gnt && mem.rvalid) ||
                      ((state == WAIT) && mem.rvalid);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            ready_o    <= 1'b1;
            wb_valid_o <= 1'b0;
            rd_wr_en_o <= 1'b0;
            rd_idx_o   <= '0;
            rd_wdata_o <= '0;
            ls_err_o   <= 1'b0;
            mem.req    <= 1'b0;
            mem.we     <= 1'b0;
            mem.addr   <= '0;
            mem.wdata  <= '0;
            mem.wmask  <= '0;
            off_q      <= '0;
            size_q     <= SZ_B;
            usign_q    <= 1'b0;
            store_q    <= 1'b0;
            rd_wr_en_q <= 1'b0;
            rd_idx_q   <= '0;
`ifdef YSYX_22040237_LSU_TIMEOUT_EN
            tmo_cnt    <= '0;
`endif
        end else begin
            wb_valid_o <= 1'b0;
            ls_err_o   <= 1'b0;

            case (state)
                IDLE: begin
                    if (valid_i && ready_o) begin
                        if (!is_load && !is_store) begin
                            wb_valid_o <= 1'b1;
                            rd_wr_en_o <= rd_wr_en_i;
                            rd_idx_o   <= rd_idx_i;
                            rd_wdata_o <= alu_res_i;
                        end else if (misaligned) begin
                            wb_valid_o <= 1'b1;
                            ls_err_o   <= 1'b1;
                            rd_wr_en_o <= 1'b0;
                            rd_idx_o   <= rd_idx_i;
                            rd_wdata_o <= '0;
                        end else begin
                            state      <= REQ;
                            ready_o    <= 1'b0;
                            mem.req    <= 1'b1;
                            mem.we     <= is_store;
                            mem.addr   <= {alu_res_i[XLEN-1:3], 3'b000};
                            mem.wdata  <= lane_wdata;
                            mem.wmask  <= lane_mask;
                            off_q      <= off;
                            size_q     <= req_size;
                            usign_q    <= ls_info_bus_i[2];
                            store_q    <= is_store;
                            rd_wr_en_q <= rd_wr_en_i;
                            rd_idx_q   <= rd_idx_i;
`ifdef YSYX_22040237_LSU_TIMEOUT_EN
                            tmo_cnt    <= '0;
`endif
                        end
                    end
                end

                REQ, WAIT: begin
                    if (rsp_done) begin
                        state      <= IDLE;
                        ready_o    <= 1'b1;
                        mem.req    <= 1'b0;
                        wb_valid_o <= 1'b1;
                        rd_wr_en_o <= rd_wr_en_q && !store_q;
                        rd_idx_o   <= rd_idx_q;
                        rd_wdata_o <= store_q ? '0 : load_data;
                    end else if ((state == REQ) && mem.gnt) begin
                        state      <= WAIT;
                        mem.req    <= 1'b0;
`ifdef YSYX_22040237_LSU_TIMEOUT_EN
                        tmo_cnt    <= '0;
`endif
                    end
`ifdef YSYX_22040237_LSU_TIMEOUT_EN
                    else if (tmo_cnt == 8'(TIMEOUT_CYC)) begin
                        state      <= IDLE;
                        ready_o    <= 1'b1;
                        mem.req    <= 1'b0;
                        wb_valid_o <= 1'b1;
                        ls_err_o   <= 1'b1;
                        rd_wr_en_o <= 1'b0;
                        rd_idx_o   <= rd_idx_q;
                        rd_wdata_o <= '0;
                    end else begin
                        tmo_cnt    <= tmo_cnt + 8'd1;
                    end
`endif
                end

                default: begin
                    state   <= IDLE;
                    ready_o <= 1'b1;
                    mem.req <= 1'b0;
                end
            endcase
        end
    end

endmodule
